// File: rtl/muldiv_iter_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_iter_unit: iterative MULT/MULTU/DIV/DIVU engine producing {HI, LO}.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module muldiv_iter_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     srca,
  input  logic [WIDTH-1:0]     srcb,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   hiloresult
);

  localparam int c_N  = WIDTH / BITS_PER_CYCLE;
  localparam int c_CW = $clog2(c_N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CW-1:0]      r_count;
  logic                 r_isDiv;
  logic                 r_negQ;
  logic                 r_negR;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_origA;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_isSigned;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic [WIDTH:0]       w_rem;
  logic [WIDTH-1:0]     w_hi;
  logic [WIDTH-1:0]     w_lo;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH-1:0]     w_r;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_accept;

  assign w_isSigned = ~op[0];
  assign w_magA     = (w_isSigned & srca[WIDTH-1]) ? -srca : srca;
  assign w_magB     = (w_isSigned & srcb[WIDTH-1]) ? -srcb : srcb;
  assign w_accept   = start & ~cancel;

  // One iteration retires BITS_PER_CYCLE bits. Multiply keeps the running
  // partial product in hi and the unconsumed multiplier in lo; divide keeps
  // the partial remainder in hi and shifts quotient bits into lo.
  always_comb begin
    w_hi  = r_hi;
    w_lo  = r_lo;
    w_rem = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_isDiv) begin
        w_rem = {w_hi, w_lo[WIDTH-1]};
        w_lo  = {w_lo[WIDTH-2:0], 1'b0};
        if (w_rem >= {1'b0, r_opnd}) begin
          w_rem   = w_rem - {1'b0, r_opnd};
          w_lo[0] = 1'b1;
        end
        w_hi = w_rem[WIDTH-1:0];
      end else begin
        w_rem = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_lo  = {w_rem[0], w_lo[WIDTH-1:1]};
        w_hi  = w_rem[WIDTH:1];
      end
    end
  end

  // Sign restoration on the final iteration; divide-by-zero bypasses the datapath.
  always_comb begin
    w_prod   = {w_hi, w_lo};
    w_q      = r_negQ ? -w_lo : w_lo;
    w_r      = r_negR ? -w_hi : w_hi;
    w_result = '0;
    if (!r_isDiv) begin
      w_result = r_negQ ? -w_prod : w_prod;
    end else if (r_opnd == '0) begin
      w_result = {r_origA, {WIDTH{1'b1}}};
    end else begin
      w_result = {w_r, w_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_isDiv  <= 1'b0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_origA  <= '0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_count <= c_CW'(c_N);
            r_isDiv <= op[1];
            r_negQ  <= w_isSigned & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            r_negR  <= w_isSigned & srca[WIDTH-1];
            r_origA <= srca;
            r_hi    <= '0;
            r_lo    <= op[1] ? w_magA : w_magB;
            r_opnd  <= op[1] ? w_magB : w_magA;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_hi    <= w_hi;
            r_lo    <= w_lo;
            r_count <= r_count - c_CW'(1);
            if (r_count == c_CW'(1)) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_result;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = ~rst & ((((r_state == S_IDLE) | (r_state == S_DONE)) & w_accept) |
                        ((r_state == S_RUN) & ~cancel));
  assign done       = r_done;
  assign hiloresult = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_iter_unit: randomized self-checking bench for muldiv_iter_unit.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_muldiv_iter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startA  [3];
  logic [1:0]  opA     [3];
  logic [31:0] srcaA   [3];
  logic [31:0] srcbA   [3];
  logic        cancelA [3];
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [63:0] hilo0, hilo1;
  logic [31:0] hilo16;
  wire  [2:0]  busyV = {busy2, busy1, busy0};
  wire  [2:0]  doneV = {done2, done1, done0};
  wire  [63:0] hiloV [3];
  assign hiloV[0] = hilo0;
  assign hiloV[1] = hilo1;
  assign hiloV[2] = {32'd0, hilo16};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(startA[0]), .op(opA[0]), .srca(srcaA[0]), .srcb(srcbA[0]),
    .cancel(cancelA[0]), .busy(busy0), .done(done0), .hiloresult(hilo0));
  muldiv_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(startA[1]), .op(opA[1]), .srca(srcaA[1]), .srcb(srcbA[1]),
    .cancel(cancelA[1]), .busy(busy1), .done(done1), .hiloresult(hilo1));
  muldiv_iter_unit #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(startA[2]), .op(opA[2]), .srca(srcaA[2][15:0]), .srcb(srcbA[2][15:0]),
    .cancel(cancelA[2]), .busy(busy2), .done(done2), .hiloresult(hilo16));

  // Architectural result from plain integer arithmetic at width w.
  function automatic logic [63:0] refModel(input int w, input logic [1:0] o,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, ua, ub, full;
    longint sa, sb, p, q, r;
    m    = (64'd1 << w) - 64'd1;
    full = (m << w) | m;
    ua   = 64'(a) & m;
    ub   = 64'(b) & m;
    sa   = (!o[0] && ua[w-1]) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = (!o[0] && ub[w-1]) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    if (!o[1]) begin
      p = sa * sb;
      return 64'(p) & full;
    end
    if (ub == 64'd0) return (ua << w) | m;
    q = sa / sb;
    r = sa % sb;
    return ((64'(r) & m) << w) | (64'(q) & m);
  endfunction

  // Issues one op on DUT d (start in cycle 0) and waits up to 200 cycles for done.
  task automatic runOp(input int d, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int doneCyc, output int busyCnt,
                       output logic busyAtDone);
    @(posedge clk); #1;
    opA[d] = o; srcaA[d] = a; srcbA[d] = b; startA[d] = 1'b1;
    doneCyc = -1; busyCnt = 0; busyAtDone = 1'bx; res = 'x;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (doneV[d]) begin
        doneCyc = c; busyAtDone = busyV[d]; res = hiloV[d];
        break;
      end
      if (busyV[d]) busyCnt++;
      @(posedge clk); #1;
      startA[d] = 1'b0; srcaA[d] = $urandom; srcbA[d] = $urandom; opA[d] = 2'($urandom);
    end
    startA[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    startA[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done0); end
    checks++; if (hilo0 !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h want 0", hilo0); end
    @(posedge clk); #1;
    startA[0] = 1'b0; rst = 1'b0;
  endtask

  task automatic test_multu_max();
    logic [63:0] res; int dc, bc; logic bd; int bad;
    runOp(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, res, dc, bc, bd);
    checks++; if (dc !== 33) begin errors++; $display("FAIL multu_done_cycle got %0d want 33", dc); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b want 0", bd); end
    checks++; if (res !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_result got %h want fffffffe00000001", res); end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0 || hilo0 !== 64'hFFFFFFFE_00000001) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_hold got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_signed();
    logic [63:0] res; int dc, bc; logic bd;
    runOp(0, 2'b00, 32'hFFFFFFFD, 32'h00000007, res, dc, bc, bd);
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_neg got %h want ffffffffffffffeb", res); end
    runOp(0, 2'b10, 32'hFFFFFFF9, 32'h00000002, res, dc, bc, bd);
    checks++; if (res !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg got %h want fffffffffffffffd", res); end
  endtask

  task automatic test_div_boundary();
    logic [63:0] res; int dc, bc; logic bd;
    runOp(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, res, dc, bc, bd);
    checks++; if (res !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow got %h want 0000000080000000", res); end
    checks++; if (dc !== 33) begin errors++; $display("FAIL div_overflow_cycle got %0d want 33", dc); end
    runOp(0, 2'b11, 32'h12345678, 32'h00000000, res, dc, bc, bd);
    checks++; if (res !== 64'h12345678_FFFFFFFF) begin errors++; $display("FAIL divu_zero got %h want 12345678ffffffff", res); end
    checks++; if (dc !== 33) begin errors++; $display("FAIL divu_zero_cycle got %0d want 33", dc); end
    runOp(0, 2'b10, 32'hFFFFFFF0, 32'h00000000, res, dc, bc, bd);
    checks++; if (res !== 64'hFFFFFFF0_FFFFFFFF) begin errors++; $display("FAIL div_zero_signed got %h want fffffff0ffffffff", res); end
  endtask

  task automatic test_cancel_reset();
    logic [63:0] res; int dc, bc; logic bd; int bad;
    runOp(0, 2'b11, 32'd100, 32'd7, res, dc, bc, bd);
    checks++; if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_100_7 got %h want 000000020000000e", res); end
    // cancel in cycle 10 of a new op
    @(posedge clk); #1;
    opA[0] = 2'b01; srcaA[0] = $urandom; srcbA[0] = $urandom; startA[0] = 1'b1;
    repeat (10) begin @(posedge clk); #1; startA[0] = 1'b0; end
    cancelA[0] = 1'b1;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", busy0); end
    @(posedge clk); #1; cancelA[0] = 1'b0;
    bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0 || hilo0 !== 64'h00000002_0000000E) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL cancel_quiet got %0d bad cycles want 0", bad); end
    // reset in cycle 10 of a new op
    @(posedge clk); #1;
    opA[0] = 2'b11; srcaA[0] = 32'd100; srcbA[0] = 32'd7; startA[0] = 1'b1;
    repeat (10) begin @(posedge clk); #1; startA[0] = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy0); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (hilo0 !== 64'd0) begin errors++; $display("FAIL rst_hilo got %h want 0", hilo0); end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0 || hilo0 !== 64'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_idle got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2; logic [63:0] r1, r2; int d1, d2, nDone; logic bAt;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'd1;
    d1 = -1; d2 = -1; nDone = 0; bAt = 1'bx; r1 = 'x; r2 = 'x;
    @(posedge clk); #1;
    opA[0] = 2'b01; srcaA[0] = a1; srcbA[0] = b1; startA[0] = 1'b1;
    @(posedge clk); #1;
    opA[0] = 2'b10; srcaA[0] = a2; srcbA[0] = b2;
    for (int c = 1; c < 120; c++) begin
      @(negedge clk);
      if (done0) begin
        nDone++;
        if (nDone == 1) begin d1 = c; r1 = hilo0; bAt = busy0; end
        else if (nDone == 2) begin d2 = c; r2 = hilo0; end
      end
      @(posedge clk); #1;
      if (nDone >= 1) startA[0] = 1'b0;
    end
    checks++; if (d1 !== 33) begin errors++; $display("FAIL b2b_first_cycle got %0d want 33", d1); end
    checks++; if (bAt !== 1'b1) begin errors++; $display("FAIL b2b_busy_at_done got %b want 1", bAt); end
    checks++; if (d2 !== 66) begin errors++; $display("FAIL b2b_second_cycle got %0d want 66", d2); end
    checks++; if (nDone !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", nDone); end
    checks++; if (r1 !== refModel(32, 2'b01, a1, b1)) begin errors++; $display("FAIL b2b_result1 got %h want %h", r1, refModel(32, 2'b01, a1, b1)); end
    checks++; if (r2 !== refModel(32, 2'b10, a2, b2)) begin errors++; $display("FAIL b2b_result2 got %h want %h", r2, refModel(32, 2'b10, a2, b2)); end
  endtask

  task automatic test_start_in_run();
    logic [31:0] a1, b1; logic [63:0] r1; int d1, nDone;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    d1 = -1; nDone = 0; r1 = 'x;
    @(posedge clk); #1;
    opA[0] = 2'b11; srcaA[0] = a1; srcbA[0] = b1; startA[0] = 1'b1;
    for (int c = 1; c < 80; c++) begin
      @(posedge clk); #1;
      startA[0] = (c == 5);
      opA[0] = 2'b00; srcaA[0] = $urandom; srcbA[0] = $urandom;
      @(negedge clk);
      if (done0) begin nDone++; if (nDone == 1) begin d1 = c; r1 = hilo0; end end
    end
    startA[0] = 1'b0;
    checks++; if (nDone !== 1) begin errors++; $display("FAIL run_start_done_count got %0d want 1", nDone); end
    checks++; if (d1 !== 33) begin errors++; $display("FAIL run_start_cycle got %0d want 33", d1); end
    checks++; if (r1 !== refModel(32, 2'b11, a1, b1)) begin errors++; $display("FAIL run_start_result got %h want %h", r1, refModel(32, 2'b11, a1, b1)); end
  endtask

  task automatic test_radix();
    logic [63:0] res; int dc, bc; logic bd;
    runOp(1, 2'b01, 32'h0000FFFF, 32'h0000FFFF, res, dc, bc, bd);
    checks++; if (dc !== 9) begin errors++; $display("FAIL r4_done_cycle got %0d want 9", dc); end
    checks++; if (bc !== 9) begin errors++; $display("FAIL r4_busy_cycles got %0d want 9", bc); end
    checks++; if (res !== 64'h00000000_FFFE0001) begin errors++; $display("FAIL r4_result got %h want 00000000fffe0001", res); end
    runOp(2, 2'b11, 32'h0000FFFF, 32'h00000003, res, dc, bc, bd);
    checks++; if (dc !== 9) begin errors++; $display("FAIL w16_done_cycle got %0d want 9", dc); end
    checks++; if (res !== 64'h00000000_00005555) begin errors++; $display("FAIL w16_result got %h want 0000000000005555", res); end
  endtask

  task automatic test_random();
    logic [63:0] res, exp; int dc, bc; logic bd; logic [1:0] o; logic [31:0] a, b;
    int widths [3] = '{32, 32, 16};
    int lat    [3] = '{33, 9, 9};
    int iters  [3] = '{30, 15, 15};
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < iters[d]; k++) begin
        o = 2'($urandom);
        a = ($urandom_range(0, 7) == 0) ? (32'd1 << (widths[d] - 1)) : $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom);
        if (widths[d] == 16) begin a = a & 32'hFFFF; b = b & 32'hFFFF; end
        exp = refModel(widths[d], o, a, b);
        runOp(d, o, a, b, res, dc, bc, bd);
        checks++; if (res !== exp) begin errors++; $display("FAIL rand_result dut%0d op%0d a=%h b=%h got %h want %h", d, o, a, b, res, exp); end
        checks++; if (dc !== lat[d]) begin errors++; $display("FAIL rand_latency dut%0d got %0d want %0d", d, dc, lat[d]); end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      startA[d] = 1'b0; opA[d] = 2'b00; srcaA[d] = '0; srcbA[d] = '0; cancelA[d] = 1'b0;
    end
    test_reset();
    test_multu_max();
    test_signed();
    test_div_boundary();
    test_cancel_reset();
    test_back_to_back();
    test_start_in_run();
    test_radix();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
